// File: rtl/alu_mem_datapath_pkg.sv
// Shared encodings for the execute/memory datapath: opcodes, condition codes,
// CPU phases, NZCV bit positions and the condition evaluator.
package alu_mem_datapath_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_ORR = 4'h4, OP_EOR = 4'h5, OP_MVN = 4'h6, OP_LSL = 4'h7,
        OP_LSR = 4'h8, OP_CMP = 4'h9, OP_LDR = 4'hA, OP_STR = 4'hB
    } op_e;

    typedef enum logic [3:0] {
        CC_AL = 4'h0, CC_EQ = 4'h1, CC_NE = 4'h2, CC_CS = 4'h3,
        CC_CC = 4'h4, CC_MI = 4'h5, CC_PL = 4'h6, CC_VS = 4'h7,
        CC_VC = 4'h8, CC_HI = 4'h9, CC_LS = 4'hA, CC_GE = 4'hB,
        CC_LT = 4'hC, CC_GT = 4'hD, CC_LE = 4'hE, CC_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_EXEC   = 2'd2,
        PH_RSVD   = 2'd3
    } phase_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cond)
            CC_AL:   cond_eval = 1'b1;
            CC_EQ:   cond_eval = z;
            CC_NE:   cond_eval = ~z;
            CC_CS:   cond_eval = c;
            CC_CC:   cond_eval = ~c;
            CC_MI:   cond_eval = n;
            CC_PL:   cond_eval = ~n;
            CC_VS:   cond_eval = v;
            CC_VC:   cond_eval = ~v;
            CC_HI:   cond_eval = c & ~z;
            CC_LS:   cond_eval = ~c | z;
            CC_GE:   cond_eval = (n == v);
            CC_LT:   cond_eval = (n != v);
            CC_GT:   cond_eval = ~z & (n == v);
            CC_LE:   cond_eval = z | (n != v);
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mem_datapath_alu_core.sv
// Combinational ALU: opcode and operands to result plus the candidate NZCV.
// C and V pass through unchanged except for the arithmetic ops.
module alu_core
    import alu_mem_datapath_pkg::*;
(
    input  logic [3:0]  op_code,
    input  logic [15:0] immediate,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  flags_cur,
    output logic [31:0] result,
    output logic [3:0]  flags_next
);

    logic [32:0] sum;
    logic [32:0] diff;

    assign sum  = {1'b0, src_a} + {1'b0, src_b};
    // diff[32] is the borrow; C is its inverse
    assign diff = {1'b0, src_a} - {1'b0, src_b};

    always_comb begin
        result     = '0;
        flags_next = flags_cur;
        case (op_code)
            OP_MOV:         result = {16'h0, immediate};
            OP_ADD:         result = sum[31:0];
            OP_SUB, OP_CMP: result = diff[31:0];
            OP_AND:         result = src_a & src_b;
            OP_ORR:         result = src_a | src_b;
            OP_EOR:         result = src_a ^ src_b;
            OP_MVN:         result = ~src_b;
            OP_LSL:         result = src_a << src_b[4:0];
            OP_LSR:         result = src_a >> src_b[4:0];
            OP_LDR, OP_STR: result = src_a;
            default:        result = '0;
        endcase

        flags_next[FLAG_N] = result[31];
        flags_next[FLAG_Z] = (result == 32'h0);
        if (op_code == OP_ADD) begin
            flags_next[FLAG_C] = sum[32];
            flags_next[FLAG_V] = (src_a[31] == src_b[31]) && (result[31] != src_a[31]);
        end else if (op_code == OP_SUB || op_code == OP_CMP) begin
            flags_next[FLAG_C] = ~diff[32];
            flags_next[FLAG_V] = (src_a[31] != src_b[31]) && (result[31] != src_a[31]);
        end
    end

endmodule

// File: rtl/alu_mem_datapath.sv
// Execute/memory datapath: ALU, NZCV register, condition check, PC vs.
// load/store address steering and the unified word-addressed RAM.
module alu_mem_datapath
    import alu_mem_datapath_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  phase,
    input  logic [15:0] pc,
    input  logic [3:0]  condition,
    input  logic [3:0]  op_code,
    input  logic        s_bit,
    input  logic [15:0] immediate,
    input  logic [31:0] source_1,
    input  logic [31:0] source_2,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        cond_pass,
    output logic [15:0] address,
    output logic        read_write,
    output logic [31:0] data_out,
    output logic [31:0] ldr_data
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [31:0]      Mem [0:MEM_DEPTH-1];
    logic [3:0]       flags_next;
    logic [IDX_W-1:0] mem_idx;
    logic             is_exec;
    logic             is_mem_op;

    alu_core u_alu (
        .op_code    (op_code),
        .immediate  (immediate),
        .src_a      (source_1),
        .src_b      (source_2),
        .flags_cur  (flags),
        .result     (result),
        .flags_next (flags_next)
    );

    assign is_exec   = (phase == PH_EXEC);
    assign is_mem_op = (op_code == OP_LDR) || (op_code == OP_STR);
    assign cond_pass = cond_eval(condition, flags);
    assign address   = (is_exec && is_mem_op) ? source_1[15:0] : pc;

    // Gating on reset lets an asserted reset cancel an in-flight store.
    assign read_write = reset && is_exec && (op_code == OP_STR) && cond_pass && enable;

    assign mem_idx  = address[IDX_W-1:0];
    assign data_out = enable ? Mem[mem_idx] : 32'h0;
    assign ldr_data = (is_exec && op_code == OP_LDR) ? data_out : result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags <= 4'b0000;
        else if (is_exec && s_bit && cond_pass)
            flags <= flags_next;
    end

    // RAM contents survive reset by design.
    always_ff @(posedge clk) begin
        if (read_write)
            Mem[mem_idx] <= source_2;
    end

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Randomized + directed bench for alu_mem_datapath against an arithmetic
// reference model of results, flags, conditions and RAM contents.
module tb_alu_mem_datapath;

    localparam int DEPTH = 256;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset, enable, s_bit;
    logic [1:0]  phase;
    logic [15:0] pc, immediate;
    logic [3:0]  condition, op_code;
    logic [31:0] source_1, source_2;
    logic [31:0] result, data_out, ldr_data;
    logic [3:0]  flags;
    logic        cond_pass, read_write;
    logic [15:0] address;

    alu_mem_datapath #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .phase(phase), .pc(pc),
        .condition(condition), .op_code(op_code), .s_bit(s_bit),
        .immediate(immediate), .source_1(source_1), .source_2(source_2),
        .result(result), .flags(flags), .cond_pass(cond_pass),
        .address(address), .read_write(read_write), .data_out(data_out),
        .ldr_data(ldr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    logic [3:0]  mf;
    logic        e_rw, e_fupd;
    logic [7:0]  e_idx;
    logic [31:0] e_s2;
    logic [3:0]  e_fnext;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [15:0] imm);
        case (op)
            0:       return {16'h0, imm};
            1:       return a + b;
            2, 9:    return a - b;
            3:       return a & b;
            4:       return a | b;
            5:       return a ^ b;
            6:       return ~b;
            7:       return a << b[4:0];
            8:       return a >> b[4:0];
            10, 11:  return a;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input int op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] res, input logic [3:0] cur);
        longint ua, ub, sa, sb, ss;
        logic n, z, c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = res[31];
        z = (res == 32'h0);
        c = cur[1];
        v = cur[0];
        if (op == 1) begin
            c  = (ua + ub) > 64'sh0FFFF_FFFF;
            ss = sa + sb;
            v  = (ss > SMAX) || (ss < SMIN);
        end else if (op == 2 || op == 9) begin
            c  = (ua >= ub);
            ss = sa - sb;
            v  = (ss > SMAX) || (ss < SMIN);
        end
        return {n, z, c, v};
    endfunction

    function automatic logic ref_cond(input int cnd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cnd)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return !c;
            5:  return n;
            6:  return !n;
            7:  return v;
            8:  return !v;
            9:  return c && !z;
            10: return !c || z;
            11: return n == v;
            12: return n != v;
            13: return !z && (n == v);
            14: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle's inputs, check all outputs against the model, stash the edge effects.
    task automatic apply(input int ph, input int op, input int cnd, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                         input logic [15:0] p, input logic en);
        logic [31:0] res, dout, ldr;
        logic [15:0] addr;
        logic        cp, ex, rw;
        phase = 2'(ph); op_code = 4'(op); condition = 4'(cnd); s_bit = sb;
        source_1 = a; source_2 = b; immediate = imm; pc = p; enable = en;
        #1;
        res  = ref_result(op, a, b, imm);
        cp   = ref_cond(cnd, mf);
        ex   = (ph == 2);
        addr = (ex && (op == 10 || op == 11)) ? a[15:0] : p;
        rw   = ex && (op == 11) && cp && en;
        dout = en ? mem_m[addr % DEPTH] : 32'h0;
        ldr  = (ex && op == 10) ? dout : res;
        chk("result", result, res);
        chk("flags", {28'h0, flags}, {28'h0, mf});
        chk("cond_pass", {31'h0, cond_pass}, {31'h0, cp});
        chk("address", {16'h0, address}, {16'h0, addr});
        chk("read_write", {31'h0, read_write}, {31'h0, rw});
        chk("data_out", data_out, dout);
        chk("ldr_data", ldr_data, ldr);
        e_rw    = rw;
        e_idx   = 8'(addr % DEPTH);
        e_s2    = b;
        e_fupd  = ex && sb && cp;
        e_fnext = ref_flags(op, a, b, res, mf);
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_rw) mem_m[e_idx] = e_s2;
        if (e_fupd) mf = e_fnext;
        #1;
    endtask

    task automatic run(input int ph, input int op, input int cnd, input logic sb,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                       input logic [15:0] p, input logic en);
        apply(ph, op, cnd, sb, a, b, imm, p, en);
        tick();
    endtask

    logic [31:0] saved;
    logic [31:0] ra;

    initial begin
        // Reset with an execute STR presented: no write strobe, flags cleared.
        reset = 1'b0; enable = 1'b1; phase = 2'd2; op_code = 4'hB; condition = 4'h0;
        s_bit = 1'b1; source_1 = 32'h10; source_2 = 32'h1234; immediate = 16'h0; pc = 16'h0;
        mf = 4'h0;
        #2;
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_rw", {31'h0, read_write}, 32'h0);
        @(posedge clk); #1;
        chk("rst_flags_edge", {28'h0, flags}, 32'h0);
        reset = 1'b1;

        // Fill the RAM through the store path so the model knows every word.
        for (int i = 0; i < DEPTH; i++)
            run(2, 11, 0, 1'b0, 32'(i), $urandom, 16'h0, 16'($urandom), 1'b1);

        // Fetch of a known instruction word.
        run(2, 11, 0, 1'b0, 32'd3, 32'hE100_0000, 16'h0, 16'h0, 1'b1);
        apply(0, 0, 0, 1'b0, 32'h0, 32'h0, 16'h0, 16'd3, 1'b1);
        chk("fetch_addr", {16'h0, address}, 32'd3);
        chk("fetch_data", data_out, 32'hE100_0000);
        chk("fetch_rw", {31'h0, read_write}, 32'h0);
        tick();

        // Signed overflow on ADD: N and V set, visible next cycle.
        apply(2, 1, 0, 1'b1, 32'h7FFF_FFFF, 32'h1, 16'h0, 16'h0, 1'b1);
        chk("add_result", result, 32'h8000_0000);
        tick();
        apply(1, 0, 0, 1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1);
        chk("add_flags", {28'h0, flags}, 32'h9);
        tick();

        // CMP equal then EQ-store commits, NE-store suppressed.
        run(2, 9, 0, 1'b1, 32'd5, 32'd5, 16'h0, 16'h0, 1'b1);
        apply(2, 11, 1, 1'b0, 32'd16, 32'hDEAD_BEEF, 16'h0, 16'h0, 1'b1);
        chk("eq_store_rw", {31'h0, read_write}, 32'h1);
        tick();
        apply(2, 11, 2, 1'b0, 32'd16, 32'h1234_5678, 16'h0, 16'h0, 1'b1);
        chk("ne_store_rw", {31'h0, read_write}, 32'h0);
        tick();
        apply(0, 0, 0, 1'b0, 32'h0, 32'h0, 16'h0, 16'd16, 1'b1);
        chk("mem16", data_out, 32'hDEAD_BEEF);
        tick();

        // LDR steering in execute vs. decode.
        apply(2, 10, 0, 1'b0, 32'd16, 32'h0, 16'h0, 16'd40, 1'b1);
        chk("ldr_addr", {16'h0, address}, 32'd16);
        chk("ldr_data_val", ldr_data, 32'hDEAD_BEEF);
        tick();
        apply(1, 10, 0, 1'b0, 32'd16, 32'h0, 16'h0, 16'd40, 1'b1);
        chk("decode_addr", {16'h0, address}, 32'd40);
        tick();

        // Address wrap, then a store with the RAM disabled.
        run(2, 11, 0, 1'b0, 32'h0000_0105, 32'hCAFE_F00D, 16'h0, 16'h0, 1'b1);
        apply(0, 0, 0, 1'b0, 32'h0, 32'h0, 16'h0, 16'd5, 1'b1);
        chk("wrap_mem5", data_out, 32'hCAFE_F00D);
        tick();
        saved = mem_m[6];
        apply(2, 11, 0, 1'b0, 32'd6, 32'h1111_1111, 16'h0, 16'h0, 1'b0);
        chk("en0_rw", {31'h0, read_write}, 32'h0);
        chk("en0_data", data_out, 32'h0);
        tick();
        apply(0, 0, 0, 1'b0, 32'h0, 32'h0, 16'h0, 16'd6, 1'b1);
        chk("en0_nowrite", data_out, saved);
        tick();

        // Random traffic; small addresses half the time so loads/stores hit known words.
        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra = 32'($urandom_range(0, 600));
            run($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom), ra, ($urandom_range(0, 3) == 0) ? ra : $urandom,
                16'($urandom), 16'($urandom), ($urandom_range(0, 7) != 0));
        end

        // Reset asserted mid-store cancels the write and clears flags.
        run(2, 1, 0, 1'b1, 32'h7FFF_FFFF, 32'h1, 16'h0, 16'h0, 1'b1);
        saved = mem_m[20];
        apply(2, 11, 0, 1'b1, 32'd20, 32'hBADB_AD00, 16'h0, 16'h0, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_flags", {28'h0, flags}, 32'h0);
        chk("midrst_rw", {31'h0, read_write}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_flags_edge", {28'h0, flags}, 32'h0);
        mf = 4'h0;
        reset = 1'b1;
        apply(0, 0, 0, 1'b0, 32'h0, 32'h0, 16'h0, 16'd20, 1'b1);
        chk("midrst_mem_kept", data_out, saved);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mem_datapath.md
# alu_mem_datapath

Execute-and-memory datapath of the 32-bit three-phase CPU. It combines three functions:
- a combinational ALU with condition-code evaluation and a registered NZCV flag register;
- the memory-access steering that selects between the PC and a load/store address;
- a word-addressed unified instruction/data RAM.

It sits between the fetch/decode state machine (which supplies the PC, the phase and the decoded instruction fields) and the register bank (which supplies operands and consumes results and load data).

## Interface
- MEM_DEPTH, 256: RAM depth in 32-bit words; power of two, 2..65536.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  RAM enable; gates RAM reads and writes.
- phase  in  2  CPU phase: 0 fetch, 1 decode, 2 execute; 3 is treated as decode.
- pc  in  16  program counter, used as the word address for fetches.
- condition  in  4  instruction[31:28].
- op_code  in  4  instruction[27:24].
- s_bit  in  1  instruction[23]; requests a flag update.
- immediate  in  16  instruction[18:3].
- source_1, source_2  in  32  register-bank operands.
- result  out  32  ALU result, combinational.
- flags  out  4  registered flags: {N,Z,C,V}.
- cond_pass  out  1  the condition evaluated against the registered flags is true.
- address  out  16  RAM word address.
- read_write  out  1  1 = write cycle, 0 = read.
- data_out  out  32  RAM read data; goes to the state machine as the instruction.
- ldr_data  out  32  load data for the register bank; equals data_out during an LDR execute, otherwise result.
- RAM array name: Mem[0:MEM_DEPTH-1]. Testbenches preload it with $readmemb.

## Operation
- Opcodes; the result is combinational and independent of the condition:
  - 0 MOV: zero-extended immediate.
  - 1 ADD: s1+s2.
  - 2 SUB: s1−s2.
  - 3 AND, 4 ORR, 5 EOR.
  - 6 MVN: ~s2.
  - 7 LSL: s1<<s2[4:0].
  - 8 LSR: logical right shift by s2[4:0].
  - 9 CMP: s1−s2; the register-bank write is suppressed externally by opcode.
  - A LDR: s1.
  - B STR: s1.
  - C–F: reserved, result 0.
- Flag computation:
  - N = result[31]; Z = (result==0).
  - ADD: C = carry out of bit 31; V = signed overflow.
  - SUB/CMP: C = NOT borrow (s1≥s2 unsigned); V = signed overflow.
  - All other ops: C and V keep their current values.
- Conditions, evaluated on the registered flags:
  - 0 AL, 1 EQ(Z), 2 NE, 3 CS(C), 4 CC, 5 MI(N), 6 PL, 7 VS(V), 8 VC.
  - 9 HI(C&!Z), A LS, B GE(N==V), C LT, D GT(!Z&N==V), E LE.
  - F NV (never true).
- Address steering:
  - During execute with op LDR/STR: address = s1[15:0].
  - Otherwise: address = pc.
- read_write = 1 only when phase=execute, op=STR, cond_pass=1 and enable=1.
- RAM index = address mod MEM_DEPTH (low log2(MEM_DEPTH) bits); upper address bits are ignored and wrap.
- Read: data_out = Mem[index] combinationally when enable=1, else 32'h0.
- Write: on the rising edge with read_write=1, Mem[index] ← source_2. On a simultaneous read of the same word, data_out shows the old value until the edge.

## Timing
- While reset is low, flags = 4'b0000 and writes are suppressed.
- Reset does not clear Mem. Asserting reset mid-write cancels that write.
- Outputs after reset: flags=0 and read_write=0; the remaining outputs follow the inputs combinationally.
- Flags update on the rising edge when phase=execute, s_bit=1 and cond_pass=1. They are visible from the next cycle onward, so the following instruction's condition sees them.
- result, address and data_out have zero-cycle latency. The store commits at the end of the execute cycle.
- Simultaneous flag update and store in one execute cycle is legal. The store uses the pre-update cond_pass.

## Structure
- Shared package: opcode constants, condition constants, phase encodings, flag bit indices (N=3, Z=2, C=1, V=0).
- Natural sub-module: alu_core. It is purely combinational: opcode/operands → result plus next NZCV. The flag register, condition logic, address mux and RAM stay in the top module.

## Test plan
- Reset, then fetch with pc=3, Mem[3]=32'hE100_0000, enable=1 → address=3, data_out=32'hE100_0000, read_write=0, flags=0.
- ADD, s_bit=1, s1=32'h7FFF_FFFF, s2=1, execute edge → result=32'h8000_0000, flags=1001 from the next cycle.
- CMP with s1=s2=5, s_bit=1; then an EQ-conditioned STR with s1=16, s2=32'hDEAD_BEEF → Mem[16]=32'hDEAD_BEEF. Repeat with NE → Mem[16] unchanged, read_write=0.
- LDR in execute, s1=16 → address=16, ldr_data=32'hDEAD_BEEF. Decode phase with the same inputs → address=pc.
- STR to s1=32'h0000_0105 with MEM_DEPTH=256 → writes Mem[5] (wrap). With enable=0 → no write and data_out=0.
- Pull reset low during an execute STR with s_bit=1 → no RAM write, flags=0, existing Mem contents intact.
